// File: rtl/backscatter_sequencer.sv
// Packet-window sequencer: synchronizes the carrier-detect trigger and steps
// GUARD -> TONE -> DATA -> HOLDOFF, driving the shift-clock, modulator and RF-gate enables.
module backscatter_sequencer #(
  parameter int GUARD_CYCLES   = 200,
  parameter int TONE_CYCLES    = 1600,
  parameter int DATA_CYCLES    = 7040,
  parameter int HOLDOFF_CYCLES = 4000,
  parameter int CNT_W          = 24
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       trigger_signal,
  input  logic       abort,
  output logic       six_hundred_khz_en,
  output logic       ten_mhz_en,
  output logic       modulator_en,
  output logic       rf_gate_en,
  output logic       busy,
  output logic       done_pulse,
  output logic [7:0] dropped_count
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_GUARD   = 3'd1;
  localparam logic [2:0] ST_TONE    = 3'd2;
  localparam logic [2:0] ST_DATA    = 3'd3;
  localparam logic [2:0] ST_HOLDOFF = 3'd4;

  localparam logic [CNT_W-1:0] GUARD_LAST   = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TONE_LAST    = CNT_W'(TONE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DATA_LAST    = CNT_W'(DATA_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLDOFF_LAST = CNT_W'(HOLDOFF_CYCLES - 1);

  logic             sync1_q, sync2_q, sync3_q;
  logic             trig_edge, trig_edge_q;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last;
  logic             done_d;
  logic [7:0]       dropped_q, dropped_d;
  logic             six_q, ten_q, mod_q, rf_q, busy_q, done_q;

  assign trig_edge = sync2_q & ~sync3_q;

  always_comb begin
    state_d   = state_q;
    done_d    = 1'b0;
    last      = 1'b0;
    dropped_d = dropped_q;

    case (state_q)
      ST_GUARD:   last = (cnt_q == GUARD_LAST);
      ST_TONE:    last = (cnt_q == TONE_LAST);
      ST_DATA:    last = (cnt_q == DATA_LAST);
      ST_HOLDOFF: last = (cnt_q == HOLDOFF_LAST);
      default:    last = 1'b0;
    endcase

    // abort takes priority over a coinciding terminal count
    case (state_q)
      ST_IDLE:    if (trig_edge_q) state_d = ST_GUARD;
      ST_GUARD:   if (abort) state_d = ST_HOLDOFF; else if (last) state_d = ST_TONE;
      ST_TONE:    if (abort) state_d = ST_HOLDOFF; else if (last) state_d = ST_DATA;
      ST_DATA: begin
        if (abort) begin
          state_d = ST_HOLDOFF;
        end else if (last) begin
          state_d = ST_HOLDOFF;
          done_d  = 1'b1;
        end
      end
      ST_HOLDOFF: if (last) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    cnt_d = (state_d != state_q || state_q == ST_IDLE) ? '0 : cnt_q + 1'b1;

    if (trig_edge_q && state_q != ST_IDLE && dropped_q != 8'hFF)
      dropped_d = dropped_q + 8'd1;
  end

  // edge is registered once more so FSM and outputs both see the trigger 3 cycles late
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      sync3_q     <= 1'b0;
      trig_edge_q <= 1'b0;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      dropped_q   <= '0;
      six_q       <= 1'b0;
      ten_q       <= 1'b0;
      mod_q       <= 1'b0;
      rf_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      sync1_q     <= trigger_signal;
      sync2_q     <= sync1_q;
      sync3_q     <= sync2_q;
      trig_edge_q <= trig_edge;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dropped_q   <= dropped_d;
      six_q       <= (state_d == ST_TONE) || (state_d == ST_DATA);
      ten_q       <= (state_d == ST_TONE);
      mod_q       <= (state_d == ST_DATA);
      rf_q        <= (state_d == ST_TONE) || (state_d == ST_DATA);
      busy_q      <= (state_d != ST_IDLE);
      done_q      <= done_d;
    end
  end

  assign six_hundred_khz_en = six_q;
  assign ten_mhz_en         = ten_q;
  assign modulator_en       = mod_q;
  assign rf_gate_en         = rf_q;
  assign busy               = busy_q;
  assign done_pulse         = done_q;
  assign dropped_count      = dropped_q;

endmodule

// File: tb/tb_backscatter_sequencer.sv
// Scoreboard bench for backscatter_sequencer: per-cycle expected output vectors are
// queued when a trigger/abort/reset is driven and compared as the DUT advances.
module tb_backscatter_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       trigger_signal;
  logic       abort;
  logic       six_hundred_khz_en, ten_mhz_en, modulator_en, rf_gate_en, busy, done_pulse;
  logic [7:0] dropped_count;

  // vector bit order: busy, six, ten, mod, rf, done
  localparam logic [5:0] V_IDLE  = 6'b000000;
  localparam logic [5:0] V_GUARD = 6'b100000;
  localparam logic [5:0] V_TONE  = 6'b111010;
  localparam logic [5:0] V_DATA  = 6'b110110;
  localparam logic [5:0] V_DONE  = 6'b100001;
  localparam logic [5:0] V_HOLD  = 6'b100000;

  typedef struct {
    logic [5:0] vec;
    int         drop;
    bit         has_drop;
  } exp_t;

  exp_t  sb_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cycle  = 0;
  string scen   = "init";

  backscatter_sequencer #(
    .GUARD_CYCLES  (4),
    .TONE_CYCLES   (3),
    .DATA_CYCLES   (5),
    .HOLDOFF_CYCLES(6),
    .CNT_W         (8)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .trigger_signal    (trigger_signal),
    .abort             (abort),
    .six_hundred_khz_en(six_hundred_khz_en),
    .ten_mhz_en        (ten_mhz_en),
    .modulator_en      (modulator_en),
    .rf_gate_en        (rf_gate_en),
    .busy              (busy),
    .done_pulse        (done_pulse),
    .dropped_count     (dropped_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [5:0] v, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.vec = v; e.drop = 0; e.has_drop = 1'b0;
      sb_q.push_back(e);
    end
  endtask

  task automatic push_drop(input logic [5:0] v, input int d);
    exp_t e;
    e.vec = v; e.drop = d; e.has_drop = 1'b1;
    sb_q.push_back(e);
  endtask

  task automatic plan(input int lead, input int g, input int t, input int d, input int dn,
                      input int h);
    push(V_IDLE, lead);
    push(V_GUARD, g);
    push(V_TONE, t);
    push(V_DATA, d);
    push(V_DONE, dn);
    push(V_HOLD, h);
  endtask

  task automatic step();
    exp_t e;
    @(posedge clock);
    #1;
    cycle++;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check($sformatf("%s outs @%0d", scen, cycle),
            {26'd0, busy, six_hundred_khz_en, ten_mhz_en, modulator_en, rf_gate_en, done_pulse},
            {26'd0, e.vec});
      if (e.has_drop)
        check($sformatf("%s dropped @%0d", scen, cycle), {24'd0, dropped_count}, e.drop);
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse();
    trigger_signal = 1'b1;
    step();
    trigger_signal = 1'b0;
  endtask

  task automatic drain();
    int budget = 200;
    while (sb_q.size() > 0 && budget > 0) begin
      step();
      budget--;
    end
    check({scen, " drain timeout"}, sb_q.size(), 0);
    sb_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; trigger_signal = 1'b0; abort = 1'b0;
    steps(2);

    scen = "reset";
    push_drop(V_IDLE, 0);
    push_drop(V_IDLE, 0);
    steps(2);
    reset = 1'b0;

    scen = "burst";
    plan(3, 4, 3, 5, 1, 5);
    push_drop(V_IDLE, 0);
    pulse();
    drain();

    scen = "drop3";
    plan(3, 4, 3, 5, 1, 5);
    plan(1, 4, 3, 5, 1, 5);
    push_drop(V_IDLE, 3);
    pulse();                 // edge k
    steps(9);
    pulse(); step();         // k+10
    pulse(); step();         // k+12
    pulse(); step();         // k+14
    steps(3);
    pulse();                 // k+19 -> first IDLE cycle
    drain();

    scen = "lastedge";
    plan(3, 4, 3, 5, 1, 5);
    push(V_IDLE, 2);
    push_drop(V_IDLE, 4);
    pulse();
    steps(17);
    pulse();                 // k+18 -> seen on HOLDOFF->IDLE edge
    drain();

    scen = "held";
    plan(3, 4, 3, 5, 1, 5);
    push(V_IDLE, 5);
    push_drop(V_IDLE, 4);
    trigger_signal = 1'b1;
    drain();
    trigger_signal = 1'b0;

    scen = "abort_idle";
    push(V_IDLE, 3);
    push_drop(V_IDLE, 4);
    abort = 1'b1;
    steps(3);
    abort = 1'b0;
    drain();

    scen = "abort_tone";
    plan(3, 4, 2, 0, 0, 6);
    push_drop(V_IDLE, 4);
    pulse();
    steps(8);                // now in 2nd TONE cycle
    abort = 1'b1;
    step();
    abort = 1'b0;
    drain();

    scen = "abort_last";
    plan(3, 4, 3, 5, 0, 6);
    push_drop(V_IDLE, 4);
    pulse();
    steps(14);               // now in last DATA cycle
    abort = 1'b1;
    step();
    abort = 1'b0;
    drain();

    scen = "saturate";
    for (int i = 0; i < 1000; i++) begin
      trigger_signal = (i % 2 == 0);
      step();
    end
    trigger_signal = 1'b0;
    steps(40);
    push_drop(V_IDLE, 255);
    step();
    for (int i = 0; i < 200; i++) begin
      trigger_signal = (i % 2 == 0);
      step();
    end
    trigger_signal = 1'b0;
    steps(40);
    push_drop(V_IDLE, 255);
    step();

    scen = "reset_mid";
    plan(3, 4, 3, 2, 0, 0);
    push_drop(V_IDLE, 0);
    push_drop(V_IDLE, 0);
    pulse();
    steps(11);               // in DATA
    reset = 1'b1;
    steps(2);
    reset = 1'b0;
    plan(3, 4, 3, 5, 1, 5);
    push_drop(V_IDLE, 0);
    pulse();
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
